// File: rtl/diffeq_pkg.sv
// Shared types and helpers for the diffeq_engine fixed-point Euler solver.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package diffeq_pkg;

  // Controller states: idle, four compute phases per Euler step, result pulse.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    C1   = 3'd1,
    C2   = 3'd2,
    C3   = 3'd3,
    C4   = 3'd4,
    DONE = 3'd5
  } state_t;

  // Operation select for the shared add/sub ALU.
  typedef enum logic {
    ALU_ADD = 1'b0,
    ALU_SUB = 1'b1
  } alu_op_t;

  // Largest value representable in a signed word of the given width.
  function automatic longint sat_max(input int width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  // Most negative value representable in a signed word of the given width.
  function automatic longint sat_min(input int width);
    return -(64'sd1 <<< (width - 1));
  endfunction

endpackage

// File: rtl/diffeq_engine_if.sv
// Run request, operand and result bundle between a controller and the solver.
// Latency: n/a (wires only).
// Backpressure: start is only honoured while the solver is idle.
interface diffeq_engine_if #(
  parameter int WIDTH  = 16,
  parameter int ITER_W = 8
);
  logic                     start;
  logic signed [WIDTH-1:0]  x0;
  logic signed [WIDTH-1:0]  y0;
  logic signed [WIDTH-1:0]  u0;
  logic signed [WIDTH-1:0]  dx;
  logic signed [WIDTH-1:0]  a;
  logic                     busy;
  logic                     done;
  logic signed [WIDTH-1:0]  x_out;
  logic signed [WIDTH-1:0]  y_out;
  logic signed [WIDTH-1:0]  u_out;
  logic [ITER_W-1:0]        iter_count;
  logic                     overflow;
  logic                     timeout;

  modport master (
    output start, x0, y0, u0, dx, a,
    input  busy, done, x_out, y_out, u_out, iter_count, overflow, timeout
  );

  modport slave (
    input  start, x0, y0, u0, dx, a,
    output busy, done, x_out, y_out, u_out, iter_count, overflow, timeout
  );
endinterface

// File: rtl/fxp_mul_sat.sv
// Signed fixed-point multiply: full product, arithmetic shift by FRAC, clamp to WIDTH.
// Latency: combinational.
// Backpressure: none; o_sat flags that the clamp was applied.
module fxp_mul_sat
  import diffeq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
) (
  input  logic signed [WIDTH-1:0] i_a,
  input  logic signed [WIDTH-1:0] i_b,
  output logic signed [WIDTH-1:0] o_p,
  output logic                    o_sat
);

  localparam int PW = 2 * WIDTH;
  localparam logic signed [PW-1:0] P_MAX = PW'(sat_max(WIDTH));
  localparam logic signed [PW-1:0] P_MIN = PW'(sat_min(WIDTH));

  logic signed [PW-1:0] w_prod;
  logic signed [PW-1:0] w_shift;

  // Operands are sign-extended to the full product width before multiplying.
  assign w_prod  = i_a * i_b;
  // Arithmetic shift truncates toward -infinity.
  assign w_shift = w_prod >>> FRAC;

  // Clamp the rescaled product into the signed WIDTH-bit range.
  always_comb begin
    o_sat = 1'b0;
    o_p   = w_shift[WIDTH-1:0];
    if (w_shift > P_MAX) begin
      o_p   = P_MAX[WIDTH-1:0];
      o_sat = 1'b1;
    end else if (w_shift < P_MIN) begin
      o_p   = P_MIN[WIDTH-1:0];
      o_sat = 1'b1;
    end
  end

endmodule

// File: rtl/diffeq_engine.sv
// Forward-Euler solver for y'' + 3xy' + 3y = 0 on two shared multipliers and one ALU.
// Latency: done pulses 4N+1 edges after the start edge for N iterations (1 edge if x0 >= a).
// Backpressure: start is ignored outside IDLE; results hold until the next accepted start.
module diffeq_engine
  import diffeq_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int FRAC     = 8,
  parameter int ITER_W   = 8,
  parameter int ITER_MAX = 255
) (
  input  logic           clk,
  input  logic           reset_n,
  diffeq_engine_if.slave bus
);

  localparam logic signed [WIDTH-1:0] THREE    = WIDTH'(3 <<< FRAC);
  localparam logic signed [WIDTH:0]   ALU_MAX  = (WIDTH + 1)'(sat_max(WIDTH));
  localparam logic signed [WIDTH:0]   ALU_MIN  = (WIDTH + 1)'(sat_min(WIDTH));
  localparam logic [ITER_W-1:0]       ITER_CAP = ITER_W'(ITER_MAX);

  state_t                  r_state;
  logic signed [WIDTH-1:0] r_x, r_y, r_u, r_dx, r_a;
  logic signed [WIDTH-1:0] r_p_ux, r_p_udx, r_p_3dx, r_p_t, r_s, r_xn, r_yn;
  logic signed [WIDTH-1:0] r_x_out, r_y_out, r_u_out;
  logic [ITER_W-1:0]       r_iter;
  logic                    r_ovf, r_tmo, r_busy, r_done;

  logic signed [WIDTH-1:0] w_m1_a, w_m1_b, w_m1_p, w_m2_p;
  logic                    w_m1_sat, w_m2_sat;
  alu_op_t                 w_alu_op;
  logic signed [WIDTH-1:0] w_alu_a, w_alu_b, w_alu_res;
  logic signed [WIDTH:0]   w_alu_wide;
  logic                    w_alu_sat;
  logic                    w_sat;
  logic [ITER_W-1:0]       w_iter_nx;

  // Route operands for m1 and the ALU according to the current compute phase.
  always_comb begin
    w_m1_a   = '0;
    w_m1_b   = '0;
    w_alu_a  = '0;
    w_alu_b  = '0;
    w_alu_op = ALU_ADD;
    case (r_state)
      C1: begin
        w_m1_a  = r_u;     w_m1_b  = r_x;      // u*x
        w_alu_a = r_x;     w_alu_b = r_dx;     // xn = x + dx
      end
      C2: begin
        w_m1_a  = THREE;   w_m1_b  = r_dx;     // 3*dx
        w_alu_a = r_p_ux;  w_alu_b = r_y;      // s = u*x + y
      end
      C3: begin
        w_m1_a  = r_p_3dx; w_m1_b  = r_s;      // 3*dx*(u*x + y)
        w_alu_a = r_y;     w_alu_b = r_p_udx;  // yn = y + u*dx
      end
      C4: begin
        w_alu_a  = r_u;    w_alu_b = r_p_t;    // un = u - p_t
        w_alu_op = ALU_SUB;
      end
      default: ;
    endcase
  end

  fxp_mul_sat #(.WIDTH(WIDTH), .FRAC(FRAC)) u_m1 (
    .i_a   (w_m1_a),
    .i_b   (w_m1_b),
    .o_p   (w_m1_p),
    .o_sat (w_m1_sat)
  );

  // m2 only ever computes u*dx, and its result is only consumed in C1.
  fxp_mul_sat #(.WIDTH(WIDTH), .FRAC(FRAC)) u_m2 (
    .i_a   (r_u),
    .i_b   (r_dx),
    .o_p   (w_m2_p),
    .o_sat (w_m2_sat)
  );

  // Add/sub one bit wider than the operands, then clamp back to WIDTH bits.
  always_comb begin
    if (w_alu_op == ALU_SUB)
      w_alu_wide = {w_alu_a[WIDTH-1], w_alu_a} - {w_alu_b[WIDTH-1], w_alu_b};
    else
      w_alu_wide = {w_alu_a[WIDTH-1], w_alu_a} + {w_alu_b[WIDTH-1], w_alu_b};
    w_alu_sat = 1'b0;
    w_alu_res = w_alu_wide[WIDTH-1:0];
    if (w_alu_wide > ALU_MAX) begin
      w_alu_res = ALU_MAX[WIDTH-1:0];
      w_alu_sat = 1'b1;
    end else if (w_alu_wide < ALU_MIN) begin
      w_alu_res = ALU_MIN[WIDTH-1:0];
      w_alu_sat = 1'b1;
    end
  end

  // m2 saturating outside C1 is irrelevant because its product is discarded.
  assign w_sat     = w_alu_sat | w_m1_sat | ((r_state == C1) & w_m2_sat);
  assign w_iter_nx = r_iter + ITER_W'(1);

  // Controller, datapath registers and registered status outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_x     <= '0;  r_y     <= '0;  r_u     <= '0;  r_dx    <= '0;  r_a  <= '0;
      r_p_ux  <= '0;  r_p_udx <= '0;  r_p_3dx <= '0;  r_p_t   <= '0;  r_s  <= '0;
      r_xn    <= '0;  r_yn    <= '0;
      r_x_out <= '0;  r_y_out <= '0;  r_u_out <= '0;
      r_iter  <= '0;
      r_ovf   <= 1'b0;
      r_tmo   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_x    <= bus.x0;
            r_y    <= bus.y0;
            r_u    <= bus.u0;
            r_dx   <= bus.dx;
            r_a    <= bus.a;
            r_iter <= '0;
            r_ovf  <= 1'b0;
            r_tmo  <= 1'b0;
            if (bus.x0 >= bus.a) begin
              // Already past the bound: report the initial point untouched.
              r_x_out <= bus.x0;
              r_y_out <= bus.y0;
              r_u_out <= bus.u0;
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_busy  <= 1'b1;
              r_state <= C1;
            end
          end
        end
        C1: begin
          r_p_ux  <= w_m1_p;
          r_p_udx <= w_m2_p;
          r_xn    <= w_alu_res;
          r_ovf   <= r_ovf | w_sat;
          r_state <= C2;
        end
        C2: begin
          r_p_3dx <= w_m1_p;
          r_s     <= w_alu_res;
          r_ovf   <= r_ovf | w_sat;
          r_state <= C3;
        end
        C3: begin
          r_p_t   <= w_m1_p;
          r_yn    <= w_alu_res;
          r_ovf   <= r_ovf | w_sat;
          r_state <= C4;
        end
        C4: begin
          r_x    <= r_xn;
          r_y    <= r_yn;
          r_u    <= w_alu_res;
          r_iter <= w_iter_nx;
          r_ovf  <= r_ovf | w_sat;
          if ((r_xn >= r_a) || (w_iter_nx == ITER_CAP)) begin
            // Bound reached takes priority over the cap on the same step.
            r_tmo   <= !(r_xn >= r_a);
            r_x_out <= r_xn;
            r_y_out <= r_yn;
            r_u_out <= w_alu_res;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_state <= C1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.x_out      = r_x_out;
  assign bus.y_out      = r_y_out;
  assign bus.u_out      = r_u_out;
  assign bus.iter_count = r_iter;
  assign bus.overflow   = r_ovf;
  assign bus.timeout    = r_tmo;

endmodule

// File: tb/tb_diffeq_engine.sv
// Directed bench for diffeq_engine: main instance with the default cap, second with cap 4.
module tb_diffeq_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        t_start;
  logic        sel4;
  logic [15:0] t_x0, t_y0, t_u0, t_dx, t_a;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  diffeq_engine_if #(.WIDTH(16), .ITER_W(8)) bus  ();
  diffeq_engine_if #(.WIDTH(16), .ITER_W(8)) bus4 ();

  assign bus.start  = t_start & ~sel4;
  assign bus.x0     = t_x0;
  assign bus.y0     = t_y0;
  assign bus.u0     = t_u0;
  assign bus.dx     = t_dx;
  assign bus.a      = t_a;
  assign bus4.start = t_start & sel4;
  assign bus4.x0    = t_x0;
  assign bus4.y0    = t_y0;
  assign bus4.u0    = t_u0;
  assign bus4.dx    = t_dx;
  assign bus4.a     = t_a;

  diffeq_engine #(.WIDTH(16), .FRAC(8), .ITER_W(8), .ITER_MAX(255)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  diffeq_engine #(.WIDTH(16), .FRAC(8), .ITER_W(8), .ITER_MAX(4)) dut4 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus4)
  );

  logic        w_busy, w_done, w_ovf, w_tmo;
  logic [15:0] w_x, w_y, w_u;
  logic [7:0]  w_iter;
  assign w_busy = sel4 ? bus4.busy       : bus.busy;
  assign w_done = sel4 ? bus4.done       : bus.done;
  assign w_ovf  = sel4 ? bus4.overflow   : bus.overflow;
  assign w_tmo  = sel4 ? bus4.timeout    : bus.timeout;
  assign w_x    = sel4 ? bus4.x_out      : bus.x_out;
  assign w_y    = sel4 ? bus4.y_out      : bus.y_out;
  assign w_u    = sel4 ? bus4.u_out      : bus.u_out;
  assign w_iter = sel4 ? bus4.iter_count : bus.iter_count;

  // Present operands with start, then count edges (start edge = 1) until done, bounded.
  task automatic launch(input logic [15:0] x0, input logic [15:0] y0, input logic [15:0] u0,
                        input logic [15:0] dx, input logic [15:0] a, input bit hold,
                        output int edges, output int busy_cyc, output bit got_done);
    t_x0 = x0; t_y0 = y0; t_u0 = u0; t_dx = dx; t_a = a;
    t_start  = 1'b1;
    edges    = 0;
    busy_cyc = 0;
    got_done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      edges++;
      if (!hold) t_start = 1'b0;
      if (w_busy) busy_cyc++;
      if (w_done) begin
        got_done = 1'b1;
        break;
      end
    end
    if (!hold) t_start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++; if (w_busy !== 1'b0) $display("FAIL rst_busy got %b want 0", w_busy); else pass_cnt++;
    total_cnt++; if (w_done !== 1'b0) $display("FAIL rst_done got %b want 0", w_done); else pass_cnt++;
    total_cnt++; if (w_x !== 16'h0000) $display("FAIL rst_x_out got %h want 0000", w_x); else pass_cnt++;
    total_cnt++; if (w_y !== 16'h0000) $display("FAIL rst_y_out got %h want 0000", w_y); else pass_cnt++;
    total_cnt++; if (w_u !== 16'h0000) $display("FAIL rst_u_out got %h want 0000", w_u); else pass_cnt++;
    total_cnt++; if (w_iter !== 8'd0) $display("FAIL rst_iter got %0d want 0", w_iter); else pass_cnt++;
    total_cnt++; if (w_ovf !== 1'b0) $display("FAIL rst_overflow got %b want 0", w_ovf); else pass_cnt++;
    total_cnt++; if (w_tmo !== 1'b0) $display("FAIL rst_timeout got %b want 0", w_tmo); else pass_cnt++;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_nominal(input string tag);
    int edges, busy_cyc;
    bit got;
    launch(16'h0000, 16'h0100, 16'h0000, 16'h0080, 16'h0100, 1'b0, edges, busy_cyc, got);
    total_cnt++; if (got !== 1'b1) $display("FAIL %s_done_seen got %b want 1", tag, got); else pass_cnt++;
    total_cnt++; if (edges != 9) $display("FAIL %s_latency got %0d want 9", tag, edges); else pass_cnt++;
    total_cnt++; if (busy_cyc != 8) $display("FAIL %s_busy_cycles got %0d want 8", tag, busy_cyc); else pass_cnt++;
    total_cnt++; if (w_x !== 16'h0100) $display("FAIL %s_x_out got %h want 0100", tag, w_x); else pass_cnt++;
    total_cnt++; if (w_y !== 16'h0040) $display("FAIL %s_y_out got %h want 0040", tag, w_y); else pass_cnt++;
    total_cnt++; if (w_u !== 16'hFE20) $display("FAIL %s_u_out got %h want fe20", tag, w_u); else pass_cnt++;
    total_cnt++; if (w_iter !== 8'd2) $display("FAIL %s_iter got %0d want 2", tag, w_iter); else pass_cnt++;
    total_cnt++; if (w_ovf !== 1'b0) $display("FAIL %s_overflow got %b want 0", tag, w_ovf); else pass_cnt++;
    total_cnt++; if (w_tmo !== 1'b0) $display("FAIL %s_timeout got %b want 0", tag, w_tmo); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (w_done !== 1'b0) $display("FAIL %s_done_width got %b want 0", tag, w_done); else pass_cnt++;
  endtask

  task automatic test_zero_iter();
    int edges, busy_cyc;
    bit got;
    launch(16'h0200, 16'h1234, 16'hABCD, 16'h0080, 16'h0100, 1'b0, edges, busy_cyc, got);
    total_cnt++; if (got !== 1'b1) $display("FAIL zero_done_seen got %b want 1", got); else pass_cnt++;
    total_cnt++; if (edges != 1) $display("FAIL zero_latency got %0d want 1", edges); else pass_cnt++;
    total_cnt++; if (busy_cyc != 0) $display("FAIL zero_busy_cycles got %0d want 0", busy_cyc); else pass_cnt++;
    total_cnt++; if (w_x !== 16'h0200) $display("FAIL zero_x_out got %h want 0200", w_x); else pass_cnt++;
    total_cnt++; if (w_y !== 16'h1234) $display("FAIL zero_y_out got %h want 1234", w_y); else pass_cnt++;
    total_cnt++; if (w_u !== 16'hABCD) $display("FAIL zero_u_out got %h want abcd", w_u); else pass_cnt++;
    total_cnt++; if (w_iter !== 8'd0) $display("FAIL zero_iter got %0d want 0", w_iter); else pass_cnt++;
    total_cnt++; if (w_tmo !== 1'b0) $display("FAIL zero_timeout got %b want 0", w_tmo); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (w_busy !== 1'b0) $display("FAIL zero_busy_after got %b want 0", w_busy); else pass_cnt++;
  endtask

  task automatic test_cap();
    int edges, busy_cyc;
    bit got;
    sel4 = 1'b1;
    launch(16'h0000, 16'h0100, 16'h0000, 16'h0000, 16'h0100, 1'b0, edges, busy_cyc, got);
    total_cnt++; if (got !== 1'b1) $display("FAIL cap_done_seen got %b want 1", got); else pass_cnt++;
    total_cnt++; if (edges != 17) $display("FAIL cap_latency got %0d want 17", edges); else pass_cnt++;
    total_cnt++; if (w_iter !== 8'd4) $display("FAIL cap_iter got %0d want 4", w_iter); else pass_cnt++;
    total_cnt++; if (w_tmo !== 1'b1) $display("FAIL cap_timeout got %b want 1", w_tmo); else pass_cnt++;
    total_cnt++; if (w_x !== 16'h0000) $display("FAIL cap_x_out got %h want 0000", w_x); else pass_cnt++;
    total_cnt++; if (w_y !== 16'h0100) $display("FAIL cap_y_out got %h want 0100", w_y); else pass_cnt++;
    @(posedge clk); #1;
    sel4 = 1'b0;
  endtask

  task automatic test_saturation();
    int edges, busy_cyc;
    bit got;
    launch(16'h0000, 16'h7F00, 16'h7F00, 16'h0100, 16'h0100, 1'b0, edges, busy_cyc, got);
    total_cnt++; if (got !== 1'b1) $display("FAIL sat_done_seen got %b want 1", got); else pass_cnt++;
    total_cnt++; if (w_y !== 16'h7FFF) $display("FAIL sat_y_out got %h want 7fff", w_y); else pass_cnt++;
    total_cnt++; if (w_u !== 16'hFF01) $display("FAIL sat_u_out got %h want ff01", w_u); else pass_cnt++;
    total_cnt++; if (w_x !== 16'h0100) $display("FAIL sat_x_out got %h want 0100", w_x); else pass_cnt++;
    total_cnt++; if (w_ovf !== 1'b1) $display("FAIL sat_overflow got %b want 1", w_ovf); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (w_ovf !== 1'b1) $display("FAIL sat_overflow_hold got %b want 1", w_ovf); else pass_cnt++;
  endtask

  task automatic test_handshake();
    int edges, busy_cyc;
    bit got;
    launch(16'h0000, 16'h0100, 16'h0000, 16'h0080, 16'h0100, 1'b1, edges, busy_cyc, got);
    total_cnt++; if (got !== 1'b1) $display("FAIL hold_done_seen got %b want 1", got); else pass_cnt++;
    total_cnt++; if (edges != 9) $display("FAIL hold_latency got %0d want 9", edges); else pass_cnt++;
    total_cnt++; if (w_y !== 16'h0040) $display("FAIL hold_y_out got %h want 0040", w_y); else pass_cnt++;
    total_cnt++; if (w_u !== 16'hFE20) $display("FAIL hold_u_out got %h want fe20", w_u); else pass_cnt++;
    total_cnt++; if (w_iter !== 8'd2) $display("FAIL hold_iter got %0d want 2", w_iter); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (w_done !== 1'b0) $display("FAIL done_start_done got %b want 0", w_done); else pass_cnt++;
    total_cnt++; if (w_busy !== 1'b0) $display("FAIL done_start_busy got %b want 0", w_busy); else pass_cnt++;
    t_start = 1'b0;
    @(posedge clk); #1;
    total_cnt++; if (w_busy !== 1'b0) $display("FAIL done_start_idle_busy got %b want 0", w_busy); else pass_cnt++;
    total_cnt++; if (w_iter !== 8'd2) $display("FAIL done_start_iter got %0d want 2", w_iter); else pass_cnt++;
  endtask

  task automatic test_reset_midrun();
    int done_seen;
    t_x0 = 16'h0000; t_y0 = 16'h0100; t_u0 = 16'h0000; t_dx = 16'h0080; t_a = 16'h0100;
    t_start = 1'b1;
    @(posedge clk); #1;
    t_start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    total_cnt++; if (w_busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", w_busy); else pass_cnt++;
    total_cnt++; if (w_done !== 1'b0) $display("FAIL midrst_done got %b want 0", w_done); else pass_cnt++;
    total_cnt++; if (w_x !== 16'h0000) $display("FAIL midrst_x_out got %h want 0000", w_x); else pass_cnt++;
    total_cnt++; if (w_y !== 16'h0000) $display("FAIL midrst_y_out got %h want 0000", w_y); else pass_cnt++;
    total_cnt++; if (w_u !== 16'h0000) $display("FAIL midrst_u_out got %h want 0000", w_u); else pass_cnt++;
    total_cnt++; if (w_iter !== 8'd0) $display("FAIL midrst_iter got %0d want 0", w_iter); else pass_cnt++;
    reset_n = 1'b1;
    done_seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (w_done || w_busy) done_seen++;
    end
    total_cnt++; if (done_seen != 0) $display("FAIL midrst_no_done got %0d want 0", done_seen); else pass_cnt++;
  endtask

  initial begin
    reset_n = 1'b0;
    t_start = 1'b0;
    sel4    = 1'b0;
    t_x0 = '0; t_y0 = '0; t_u0 = '0; t_dx = '0; t_a = '0;
    test_reset();
    test_nominal("nom");
    test_zero_iter();
    test_cap();
    test_saturation();
    test_nominal("clr");
    test_handshake();
    test_reset_midrun();
    test_nominal("post");
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
